// File: rtl/oserdes_burst_seq_if.sv
// Request/response bundle for oserdes_burst_seq.
// Carries the burst request (i_start, i_data) and the handshake/status outputs
// (o_ready, o_busy, o_done).
// Also carries the per-cycle serializer words for the DQ lanes and DQS.
// Ports (signals):
//   i_start    burst request, accepted when i_start & o_ready
//   i_data     burst payload, i_data[DQ_WIDTH*b+i] = beat b, lane i
//   o_ready    request can be accepted this cycle
//   o_busy     sequencer is outside IDLE
//   o_done     one-cycle pulse on return to IDLE
//   o_dq_din   o_dq_din[4*i+k] = lane i serializer D(k+1)
//   o_dq_tin   shared DQ tristate word, 1 = high-Z
//   o_dqs_din  DQS serializer data word
//   o_dqs_tin  DQS tristate word, 1 = high-Z
interface oserdes_burst_seq_if #(
  parameter int unsigned DQ_WIDTH    = 8,
  parameter int unsigned BURST_BEATS = 8
);
  logic                            i_start;
  logic [DQ_WIDTH*BURST_BEATS-1:0] i_data;
  logic                            o_ready;
  logic                            o_busy;
  logic                            o_done;
  logic [4*DQ_WIDTH-1:0]           o_dq_din;
  logic [3:0]                      o_dq_tin;
  logic [3:0]                      o_dqs_din;
  logic [3:0]                      o_dqs_tin;

  modport master (
    output i_start, i_data,
    input  o_ready, o_busy, o_done, o_dq_din, o_dq_tin, o_dqs_din, o_dqs_tin
  );

  modport slave (
    input  i_start, i_data,
    output o_ready, o_busy, o_done, o_dq_din, o_dq_tin, o_dqs_din, o_dqs_tin
  );
endinterface

// File: rtl/oserdes_burst_seq.sv
// Write-burst sequencer for one DDR3 byte lane, clocked in the clk_div domain
// of the lane's 4:1 output serializers.
// Each accepted burst is played out as:
//   - an optional DQS preamble,
//   - BURST_BEATS/4 data cycles, and
//   - an optional DQS postamble.
// A request arriving in the last data cycle is merged seamlessly.
// Ports:
//   clk  clk_div-domain clock, rising edge
//   rst  asynchronous active-high reset
//   bus  slave side of oserdes_burst_seq_if (request, status, serializer words)
module oserdes_burst_seq #(
  parameter int unsigned DQ_WIDTH    = 8,
  parameter int unsigned BURST_BEATS = 8,
  parameter int unsigned PRE_SLOTS   = 1,
  parameter int unsigned POST_SLOTS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  oserdes_burst_seq_if.slave  bus
);

  localparam int unsigned DataCycles = BURST_BEATS / 4;
  localparam int unsigned CntMax     = ((DataCycles - 1) > 15) ? (DataCycles - 1) : 15;
  localparam int unsigned CntW       = $clog2(CntMax + 1);
  localparam int unsigned PayloadW   = DQ_WIDTH * BURST_BEATS;
  localparam int unsigned WordW      = 4 * DQ_WIDTH;

  localparam logic [CntW-1:0] PreLast  = CntW'((PRE_SLOTS > 0) ? PRE_SLOTS - 1 : 0);
  localparam logic [CntW-1:0] PostLast = CntW'((POST_SLOTS > 0) ? POST_SLOTS - 1 : 0);
  localparam logic [CntW-1:0] DataLast = CntW'(DataCycles - 1);

  localparam logic [3:0] DqsToggle = 4'b0101;  // D1 = 1, D2 = 0, D3 = 1, D4 = 0

  typedef enum logic [1:0] {StIdle, StPre, StData, StPost} state_e;

  state_e               r_state;
  logic [CntW-1:0]      r_cnt;
  logic [PayloadW-1:0]  r_payload;
  logic [WordW-1:0]     r_dq_din;
  logic [3:0]           r_dq_tin;
  logic [3:0]           r_dqs_din;
  logic [3:0]           r_dqs_tin;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_ready;
  logic                 w_accept;
  logic [CntW-1:0]      w_cnt_nxt;
  logic [WordW-1:0]     w_word_new;
  logic [WordW-1:0]     w_word_first;
  logic [WordW-1:0]     w_word_next;

  // Gather beats 4c..4c+3 of every lane into one serializer word.
  function automatic logic [WordW-1:0] beat_word(input logic [PayloadW-1:0] p,
                                                 input logic [CntW-1:0] c);
    logic [WordW-1:0] w;
    w = '0;
    for (int i = 0; i < DQ_WIDTH; i++) begin
      for (int k = 0; k < 4; k++) begin
        w[4*i+k] = p[DQ_WIDTH*(4*int'(c)+k)+i];
      end
    end
    return w;
  endfunction

  assign w_ready  = (r_state == StIdle) | ((r_state == StData) & (r_cnt == DataLast));
  assign w_accept = bus.i_start & w_ready;

  always_comb begin
    // Clamped so the beat select never leaves the payload, even in PRE/POST.
    w_cnt_nxt    = (r_cnt >= DataLast) ? '0 : r_cnt + 1'b1;
    // First word straight from the input: the payload register loads at the same edge.
    w_word_new   = beat_word(bus.i_data, '0);
    w_word_first = beat_word(r_payload, '0);
    w_word_next  = beat_word(r_payload, w_cnt_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_payload <= '0;
      r_dq_din  <= '0;
      r_dq_tin  <= 4'hF;
      r_dqs_din <= 4'h0;
      r_dqs_tin <= 4'hF;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_payload <= bus.i_data;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_dqs_tin <= 4'h0;
            if (PRE_SLOTS > 0) begin
              r_state <= StPre;
            end else begin
              r_state   <= StData;
              r_dq_din  <= w_word_new;
              r_dq_tin  <= 4'h0;
              r_dqs_din <= DqsToggle;
            end
          end
        end
        StPre: begin
          if (r_cnt == PreLast) begin
            r_state   <= StData;
            r_cnt     <= '0;
            r_dq_din  <= w_word_first;
            r_dq_tin  <= 4'h0;
            r_dqs_din <= DqsToggle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_cnt == DataLast) begin
            r_cnt <= '0;
            if (bus.i_start) begin
              // Seamless merge: DQS keeps toggling, no pre/postamble.
              r_payload <= bus.i_data;
              r_dq_din  <= w_word_new;
            end else begin
              r_dq_din  <= '0;
              r_dq_tin  <= 4'hF;
              r_dqs_din <= 4'h0;
              if (POST_SLOTS > 0) begin
                r_state <= StPost;
              end else begin
                r_state   <= StIdle;
                r_dqs_tin <= 4'hF;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
              end
            end
          end else begin
            r_cnt    <= w_cnt_nxt;
            r_dq_din <= w_word_next;
          end
        end
        StPost: begin
          if (r_cnt == PostLast) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_dqs_tin <= 4'hF;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_ready   = w_ready;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_dq_din  = r_dq_din;
  assign bus.o_dq_tin  = r_dq_tin;
  assign bus.o_dqs_din = r_dqs_din;
  assign bus.o_dqs_tin = r_dqs_tin;

endmodule

// File: tb/tb_oserdes_burst_seq.sv
module tb_oserdes_burst_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oserdes_burst_seq_if #(.DQ_WIDTH(8),  .BURST_BEATS(8))  bus_a ();
  oserdes_burst_seq_if #(.DQ_WIDTH(8),  .BURST_BEATS(4))  bus_b ();
  oserdes_burst_seq_if #(.DQ_WIDTH(16), .BURST_BEATS(16)) bus_c ();

  oserdes_burst_seq #(.DQ_WIDTH(8), .BURST_BEATS(8), .PRE_SLOTS(1), .POST_SLOTS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  oserdes_burst_seq #(.DQ_WIDTH(8), .BURST_BEATS(4), .PRE_SLOTS(0), .POST_SLOTS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );
  oserdes_burst_seq #(.DQ_WIDTH(16), .BURST_BEATS(16), .PRE_SLOTS(2), .POST_SLOTS(3)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic [63:0] data;
    logic        rdy;
    logic        busy;
    logic        done;
    logic [31:0] dq;
    logic [3:0]  dqt;
    logic [3:0]  dqsd;
    logic [3:0]  dqst;
  } vec_t;

  vec_t vecs[$];
  int   next_idx = 0;

  localparam logic [63:0] DatX = 64'h0706050403020100;
  localparam logic [63:0] DatO = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DatY = 64'h00FF00FF00FF00FF;

  task automatic add(input logic s, input logic [63:0] d, input logic r, input logic b,
                     input logic dn, input logic [31:0] dq, input logic [3:0] dqt,
                     input logic [3:0] dqsd, input logic [3:0] dqst);
    vec_t v;
    v.start = s; v.data = d; v.rdy = r; v.busy = b; v.done = dn;
    v.dq = dq; v.dqt = dqt; v.dqsd = dqsd; v.dqst = dqst;
    vecs.push_back(v);
  endtask

  task automatic add_pre(input logic s, input logic [63:0] d);
    add(s, d, 1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 4'h0, 4'h0);
  endtask
  task automatic add_data(input logic s, input logic [63:0] d, input logic r,
                          input logic [31:0] dq);
    add(s, d, r, 1'b1, 1'b0, dq, 4'h0, 4'h5, 4'h0);
  endtask
  task automatic add_post(input logic s, input logic [63:0] d);
    add(s, d, 1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 4'h0, 4'h0);
  endtask
  task automatic add_idle(input logic s, input logic [63:0] d, input logic dn);
    add(s, d, 1'b1, 1'b0, dn, 32'h0, 4'hF, 4'h0, 4'hF);
  endtask

  // Drive each pending row at the falling edge, check 1 time unit after the rising edge.
  task automatic run_vecs();
    while (next_idx < vecs.size()) begin
      vec_t v;
      v = vecs[next_idx];
      @(negedge clk);
      bus_a.i_start = v.start;
      bus_a.i_data  = v.data;
      @(posedge clk);
      #1;
      check($sformatf("v%0d ready", next_idx),   64'(bus_a.o_ready),   64'(v.rdy));
      check($sformatf("v%0d busy", next_idx),    64'(bus_a.o_busy),    64'(v.busy));
      check($sformatf("v%0d done", next_idx),    64'(bus_a.o_done),    64'(v.done));
      check($sformatf("v%0d dq_din", next_idx),  64'(bus_a.o_dq_din),  64'(v.dq));
      check($sformatf("v%0d dq_tin", next_idx),  64'(bus_a.o_dq_tin),  64'(v.dqt));
      check($sformatf("v%0d dqs_din", next_idx), 64'(bus_a.o_dqs_din), 64'(v.dqsd));
      check($sformatf("v%0d dqs_tin", next_idx), 64'(bus_a.o_dqs_tin), 64'(v.dqst));
      next_idx++;
    end
  endtask

  logic [255:0] data_c;
  logic [63:0]  exp_c;

  initial begin
    rst = 1'b1;
    bus_a.i_start = 1'b0; bus_a.i_data = '0;
    bus_b.i_start = 1'b0; bus_b.i_data = '0;
    bus_c.i_start = 1'b0; bus_c.i_data = '0;
    #1;
    check("rst ready",   64'(bus_a.o_ready),   64'd1);
    check("rst busy",    64'(bus_a.o_busy),    64'd0);
    check("rst done",    64'(bus_a.o_done),    64'd0);
    check("rst dq_din",  64'(bus_a.o_dq_din),  64'd0);
    check("rst dq_tin",  64'(bus_a.o_dq_tin),  64'hF);
    check("rst dqs_din", 64'(bus_a.o_dqs_din), 64'd0);
    check("rst dqs_tin", 64'(bus_a.o_dqs_tin), 64'hF);
    @(negedge clk);
    rst = 1'b0;

    // Single burst: lane0 bits 0,1,0,1 -> 4'hA, lane1 0,0,1,1 -> 4'hC, lane2 high beats 4..7.
    add_pre (1'b1, DatX);
    add_data(1'b0, '0, 1'b0, 32'h0000_00CA);
    add_data(1'b0, '0, 1'b1, 32'h0000_0FCA);
    add_post(1'b0, '0);
    add_idle(1'b0, '0, 1'b1);
    add_idle(1'b0, '0, 1'b0);
    // Back-to-back merge in the last data cycle.
    add_pre (1'b1, DatX);
    add_data(1'b0, '0, 1'b0, 32'h0000_00CA);
    add_data(1'b0, '0, 1'b1, 32'h0000_0FCA);
    add_data(1'b1, DatO, 1'b0, 32'hFFFF_FFFF);
    add_data(1'b0, '0, 1'b1, 32'hFFFF_FFFF);
    add_post(1'b0, '0);
    add_idle(1'b0, '0, 1'b1);
    // start held through PRE, first data cycle and POST: ignored there.
    add_pre (1'b1, DatX);
    add_data(1'b1, DatY, 1'b0, 32'h0000_00CA);
    add_data(1'b1, DatY, 1'b1, 32'h0000_0FCA);
    add_post(1'b0, DatY);
    add_idle(1'b1, DatY, 1'b1);
    add_pre (1'b1, DatY);
    add_data(1'b0, '0, 1'b0, 32'h5555_5555);
    add_data(1'b0, '0, 1'b1, 32'h5555_5555);
    add_post(1'b0, '0);
    add_idle(1'b0, '0, 1'b1);
    run_vecs();

    // No pre/postamble, single-cycle bursts, including a merge.
    @(negedge clk);
    bus_b.i_start = 1'b1; bus_b.i_data = 32'h0F0E0D0C;
    @(posedge clk); #1;
    check("b0 dq_din",  64'(bus_b.o_dq_din),  64'h0000_FFCA);
    check("b0 dq_tin",  64'(bus_b.o_dq_tin),  64'h0);
    check("b0 dqs_din", 64'(bus_b.o_dqs_din), 64'h5);
    check("b0 ready",   64'(bus_b.o_ready),   64'd1);
    @(negedge clk);
    bus_b.i_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("b1 dq_din",  64'(bus_b.o_dq_din),  64'hFFFF_FFFF);
    check("b1 done",    64'(bus_b.o_done),    64'd0);
    check("b1 dqs_tin", 64'(bus_b.o_dqs_tin), 64'h0);
    @(negedge clk);
    bus_b.i_start = 1'b0;
    @(posedge clk); #1;
    check("b2 done",    64'(bus_b.o_done),    64'd1);
    check("b2 busy",    64'(bus_b.o_busy),    64'd0);
    check("b2 dq_tin",  64'(bus_b.o_dq_tin),  64'hF);
    check("b2 dqs_tin", 64'(bus_b.o_dqs_tin), 64'hF);

    // Asynchronous reset in the middle of a data cycle.
    @(negedge clk);
    bus_a.i_start = 1'b1; bus_a.i_data = DatX;
    @(negedge clk);
    bus_a.i_start = 1'b0;
    @(posedge clk); #1;
    check("r data busy", 64'(bus_a.o_busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("r dq_din",  64'(bus_a.o_dq_din),  64'd0);
    check("r dq_tin",  64'(bus_a.o_dq_tin),  64'hF);
    check("r dqs_din", 64'(bus_a.o_dqs_din), 64'd0);
    check("r dqs_tin", 64'(bus_a.o_dqs_tin), 64'hF);
    check("r busy",    64'(bus_a.o_busy),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    add_pre (1'b1, DatY);
    add_data(1'b0, '0, 1'b0, 32'h5555_5555);
    add_data(1'b0, '0, 1'b1, 32'h5555_5555);
    add_post(1'b0, '0);
    add_idle(1'b0, '0, 1'b1);
    run_vecs();

    // Wide configuration: 2 preamble, 4 data, 3 postamble cycles.
    for (int w = 0; w < 8; w++) data_c[32*w +: 32] = $urandom;
    bus_c.i_data = data_c;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      bus_c.i_start = (cyc == 1);
      @(posedge clk); #1;
      if (cyc >= 3 && cyc <= 6) begin
        exp_c = '0;
        for (int i = 0; i < 16; i++) begin
          for (int k = 0; k < 4; k++) exp_c[4*i+k] = data_c[16*(4*(cyc-3)+k)+i];
        end
        check($sformatf("c%0d dq_din", cyc),  64'(bus_c.o_dq_din),  exp_c);
        check($sformatf("c%0d dq_tin", cyc),  64'(bus_c.o_dq_tin),  64'h0);
        check($sformatf("c%0d dqs_din", cyc), 64'(bus_c.o_dqs_din), 64'h5);
      end else begin
        check($sformatf("c%0d dq_din", cyc),  64'(bus_c.o_dq_din),  64'h0);
        check($sformatf("c%0d dq_tin", cyc),  64'(bus_c.o_dq_tin),  64'hF);
        check($sformatf("c%0d dqs_din", cyc), 64'(bus_c.o_dqs_din), 64'h0);
      end
      check($sformatf("c%0d dqs_tin", cyc), 64'(bus_c.o_dqs_tin), (cyc >= 10) ? 64'hF : 64'h0);
      check($sformatf("c%0d done", cyc),    64'(bus_c.o_done),    64'(cyc == 10));
      check($sformatf("c%0d busy", cyc),    64'(bus_c.o_busy),    64'(cyc < 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oserdes_burst_seq.md
Name: oserdes_burst_seq

Overview:
Parametrised write-burst sequencer for one DDR3 byte lane, running in the clk_div domain of the lane's 4:1 DDR output serializers.
- Accepts one full burst of DQ data per request.
- Generates, per clk_div cycle, the 4-beat parallel data and tristate words for every DQ serializer and for the DQS serializer.
- Inserts a programmable DQS preamble and postamble.
- Merges back-to-back requests into a seamless stream with no gap.

Parameters:
DQ_WIDTH, 8, number of DQ lanes served (1..16)
BURST_BEATS, 8, beats per burst; multiple of 4, 4..64; burst occupies BURST_BEATS/4 cycles
PRE_SLOTS, 1, clk cycles of DQS preamble before data (0..15)
POST_SLOTS, 1, clk cycles of DQS postamble after data (0..15)

Ports:
clk  input  1  clk_div-domain clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  burst request; accepted when start & ready
data  input  DQ_WIDTH*BURST_BEATS  burst payload; data[DQ_WIDTH*b+i] = beat b, lane i; sampled on acceptance
ready  output  1  request can be accepted this cycle (combinational from state/counter)
busy  output  1  registered; high in any non-IDLE state
done  output  1  registered one-cycle pulse on return to IDLE
dq_din  output  4*DQ_WIDTH  dq_din[4*i+k] = lane i serializer D(k+1); D1 is transmitted first
dq_tin  output  4  shared DQ tristate word; 1 = high-Z
dqs_din  output  4  DQS serializer data word
dqs_tin  output  4  DQS tristate word; 1 = high-Z

Behaviour:
- States: IDLE, PRE, DATA, POST. All data/tristate outputs are registered and reflect the state entered at that edge.
- Reset (asynchronous, any state, including mid-burst): state = IDLE, counters = 0, dq_din = 0, dqs_din = 0, dq_tin = 4'hF, dqs_tin = 4'hF, busy = 0, done = 0. Data latched for an aborted burst is discarded; there is no resume.
- ready = (state == IDLE) | (state == DATA & last data cycle). ready is low in PRE and POST; start in those states is ignored and not queued.
- IDLE:
  - Outputs as at reset.
  - On acceptance, latch data.
  - Go to PRE if PRE_SLOTS > 0, else DATA.
  - The first non-idle output appears at the edge after acceptance (latency 1).
- PRE (PRE_SLOTS cycles): dqs_tin = 0, dqs_din = 4'b0000, dq_tin = 4'hF, dq_din = 0. Go to DATA.
- DATA (BURST_BEATS/4 cycles, cycle index c = 0..BURST_BEATS/4-1):
  - dq_din[4*i+k] = latched beat (4c+k), lane i.
  - dq_tin = 0, dqs_tin = 0, dqs_din = 4'b0101 (D1 = 1, D2 = 0, D3 = 1, D4 = 0).
- Last DATA cycle:
  - If start is also high: latch the new data and stay in DATA with c = 0 (no preamble/postamble, continuous DQS).
  - Else go to POST if POST_SLOTS > 0, else IDLE.
- POST (POST_SLOTS cycles): dqs_tin = 0, dqs_din = 4'b0000, dq_tin = 4'hF, dq_din = 0. Then IDLE.
- done: one-cycle pulse at the edge that enters IDLE from POST or from DATA. It is not asserted on a seamless merge.
- Counters: one slot counter, wide enough for max(15, BURST_BEATS/4 - 1). It reloads on every state entry and on a seamless merge.
- The latched payload register is written only on acceptance; it holds otherwise.

Test Plan:
1. Single burst with defaults (DQ_WIDTH=8, BURST_BEATS=8, PRE=1, POST=1). data = 64'h0706050403020100, start pulse at cycle 0 ->
   - cycle 1 PRE: dqs_tin = 0, dqs_din = 0, dq_tin = F.
   - cycles 2–3 DATA: dq_tin = 0, dqs_din = 5; lane 0 D1..D4 = beats 0..3 bit 0 = 0,1,0,1.
   - cycle 4 POST.
   - cycle 5: IDLE, done = 1, all tristates = F.
2. Back-to-back: second start held during cycle 3 (ready = 1) with data = all-ones -> DATA continues in cycles 4–5 with dq_din all ones, dqs_tin stays 0, no POST/PRE between bursts, one done pulse at cycle 7.
3. PRE_SLOTS = 0, POST_SLOTS = 0, BURST_BEATS = 4 -> DATA in cycle 1 only, IDLE with done = 1 at cycle 2.
4. start held high through PRE and POST -> ready = 0 in those states and no burst is accepted there; acceptance occurs only in IDLE or the last DATA cycle.
5. Reset asserted asynchronously mid-DATA (between edges) -> outputs immediately return to reset values (tin = F, din = 0, busy = 0). After release, the first start produces a full PRE + DATA + POST with the new data.
6. DQ_WIDTH = 16, BURST_BEATS = 16, PRE = 2, POST = 3, random data -> scoreboard checks every beat per lane over 4 DATA cycles and the exact 2/3-cycle preamble/postamble widths.
